dac_perturb_sequencer: RTL and testbench

// - DAC-side counterpart of the ADC averaging path in the SPGD loop: drives the DAC with base+/-perturbation,

---
 rtl/dac_perturb_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_dac_perturb_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_perturb_sequencer.sv
// dac_perturb_sequencer
// DAC-side sequencer of the SPGD loop. Each iteration drives the DAC with base+delta, waits for the
// analog path to settle, requests one ADC average, repeats with base-delta, then moves the base code
// by (J_P - J_M) >>> GAIN_SHIFT (gradient ascent on the metric J).
//
// Ports
//   ADC_CLK        in   single clock, rising edge
//   RST            in   synchronous active-high reset
//   START          in   level enable; iterations repeat while high
//   DELTA          in   perturbation amplitude, latched when an iteration starts
//   AVG_DATA       in   averaged metric J, qualified by AVG_VALID
//   AVG_VALID      in   one-cycle strobe from the averager
//   AVG_START      out  one-cycle request to the averager (first MEAS cycle)
//   DAC_CODE_OUT   out  registered code to the DAC
//   BASE_CODE_OUT  out  current unperturbed base code
//   BUSY           out  high in every state except idle
//   DONE           out  one-cycle pulse in the update cycle
//
// Build option
//   PERTURB_LFSR_EN  when defined, the perturbation sign comes from bit0 of a 16-bit Fibonacci LFSR
//                    (x^16+x^14+x^13+x^11+1, seed 16'hACE1) that advances once per update.
//                    When undefined the sign is fixed at +1 and no LFSR exists.

module dac_perturb_sequencer #(
   parameter int unsigned DAC_WIDTH     = 14,
   parameter int unsigned AVG_WIDTH     = 12,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned GAIN_SHIFT    = 4
) (
   input  logic                 ADC_CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [DAC_WIDTH-1:0] DELTA,
   input  logic [AVG_WIDTH-1:0] AVG_DATA,
   input  logic                 AVG_VALID,
   output logic                 AVG_START,
   output logic [DAC_WIDTH-1:0] DAC_CODE_OUT,
   output logic [DAC_WIDTH-1:0] BASE_CODE_OUT,
   output logic                 BUSY,
   output logic                 DONE
);

   // Signed working width: one bit of headroom above the code range plus a sign bit.
   localparam int unsigned SW   = DAC_WIDTH + 2;
   localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [CntW-1:0]      SettleLoad = CntW'(SETTLE_CYCLES - 1);
   localparam logic [DAC_WIDTH-1:0] MidCode    = {1'b1, {(DAC_WIDTH-1){1'b0}}};
   localparam logic signed [SW-1:0] MaxCode    = $signed({2'b00, {DAC_WIDTH{1'b1}}});

   typedef enum logic [2:0] {
      StIdle,
      StSetP,
      StSettleP,
      StMeasP,
      StSetM,
      StSettleM,
      StMeasM,
      StUpdate
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [DAC_WIDTH-1:0] base_q, base_d;
   logic [DAC_WIDTH-1:0] dac_q, dac_d;
   logic [DAC_WIDTH-1:0] delta_q, delta_d;
   logic [AVG_WIDTH-1:0] jp_q, jp_d;
   logic [AVG_WIDTH-1:0] jm_q, jm_d;
   logic                 avg_start_q, avg_start_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic signed [SW-1:0]      base_s, delta_s, offs_s, plus_s, minus_s;
   logic signed [AVG_WIDTH:0] dj_s, step_j;
   logic signed [SW-1:0]      step_s, upd_s;

   function automatic logic [DAC_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
      if (v[SW-1]) begin
         return '0;
      end else if (v > MaxCode) begin
         return '1;
      end else begin
         return v[DAC_WIDTH-1:0];
      end
   endfunction

`ifdef PERTURB_LFSR_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic        sign_pos;
   assign sign_pos = lfsr_q[0];
`else
   logic        sign_pos;
   assign sign_pos = 1'b1;
`endif

   always_comb begin
      base_s  = $signed({2'b00, base_q});
      delta_s = $signed({2'b00, delta_q});
      offs_s  = sign_pos ? delta_s : -delta_s;
      plus_s  = base_s + offs_s;
      minus_s = base_s - offs_s;
      dj_s    = $signed({1'b0, jp_q}) - $signed({1'b0, jm_q});
      step_j  = dj_s >>> GAIN_SHIFT;
      step_s  = SW'(step_j);
      upd_s   = sign_pos ? (base_s + step_s) : (base_s - step_s);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      dac_d       = dac_q;
      delta_d     = delta_q;
      jp_d        = jp_q;
      jm_d        = jm_q;
      avg_start_d = 1'b0;
      done_d      = 1'b0;
`ifdef PERTURB_LFSR_EN
      lfsr_d      = lfsr_q;
`endif
      case (state_q)
         StIdle: begin
            if (START) begin
               state_d = StSetP;
               delta_d = DELTA;
            end
         end
         StSetP: begin
            dac_d   = sat(plus_s);
            cnt_d   = SettleLoad;
            state_d = StSettleP;
         end
         StSettleP: begin
            if (cnt_q == '0) begin
               state_d     = StMeasP;
               avg_start_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StMeasP: begin
            if (AVG_VALID) begin
               jp_d    = AVG_DATA;
               state_d = StSetM;
            end
         end
         StSetM: begin
            dac_d   = sat(minus_s);
            cnt_d   = SettleLoad;
            state_d = StSettleM;
         end
         StSettleM: begin
            if (cnt_q == '0) begin
               state_d     = StMeasM;
               avg_start_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StMeasM: begin
            if (AVG_VALID) begin
               jm_d    = AVG_DATA;
               state_d = StUpdate;
               done_d  = 1'b1;  // DONE is high for the whole update cycle
            end
         end
         StUpdate: begin
            base_d = sat(upd_s);
            dac_d  = sat(upd_s);
`ifdef PERTURB_LFSR_EN
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
            if (START) begin
               state_d = StSetP;
               delta_d = DELTA;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge ADC_CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         base_q      <= MidCode;
         dac_q       <= MidCode;
         delta_q     <= '0;
         jp_q        <= '0;
         jm_q        <= '0;
         avg_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef PERTURB_LFSR_EN
         lfsr_q      <= 16'hACE1;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         base_q      <= base_d;
         dac_q       <= dac_d;
         delta_q     <= delta_d;
         jp_q        <= jp_d;
         jm_q        <= jm_d;
         avg_start_q <= avg_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef PERTURB_LFSR_EN
         lfsr_q      <= lfsr_d;
`endif
      end
   end

   assign AVG_START     = avg_start_q;
   assign DAC_CODE_OUT  = dac_q;
   assign BASE_CODE_OUT = base_q;
   assign BUSY          = busy_q;
   assign DONE          = done_q;

endmodule

// File: tb/tb_dac_perturb_sequencer.sv
// Directed self-checking bench for dac_perturb_sequencer (default parameters). The bench plays the
// averager: it answers each AVG_START with a chosen J value and checks DAC codes, base updates,
// DONE/BUSY timing, ignored strobes, START drop, and reset mid-operation.

module tb_dac_perturb_sequencer;

   logic        ADC_CLK;
   logic        RST;
   logic        START;
   logic [13:0] DELTA;
   logic [11:0] AVG_DATA;
   logic        AVG_VALID;
   logic        AVG_START;
   logic [13:0] DAC_CODE_OUT;
   logic [13:0] BASE_CODE_OUT;
   logic        BUSY;
   logic        DONE;

   int n_checks = 0;
   int n_errors = 0;

   dac_perturb_sequencer dut (
      .ADC_CLK       (ADC_CLK),
      .RST           (RST),
      .START         (START),
      .DELTA         (DELTA),
      .AVG_DATA      (AVG_DATA),
      .AVG_VALID     (AVG_VALID),
      .AVG_START     (AVG_START),
      .DAC_CODE_OUT  (DAC_CODE_OUT),
      .BASE_CODE_OUT (BASE_CODE_OUT),
      .BUSY          (BUSY),
      .DONE          (DONE)
   );

   initial ADC_CLK = 1'b0;
   always #5 ADC_CLK = ~ADC_CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Outputs are sampled on the falling edge; inputs are changed right after sampling.
   task automatic wait_avg_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge ADC_CLK);
         if (AVG_START) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge ADC_CLK);
         if (DONE) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One full iteration. next_delta/next_start are applied during the DONE cycle so they are taken
   // on the edge leaving UPDATE. glitch: strobe AVG_VALID in SETTLE_P (only when the previous
   // iteration chained straight into SET_P). drop: release START in SETTLE_M.
   task automatic do_iter(input int jp, input int jm, input int m_delay, input int next_delta,
                          input bit next_start, input int exp_p, input int exp_m, input int exp_base,
                          input bit glitch, input bit drop);
      bit ok;
      if (glitch) begin
         @(negedge ADC_CLK);
         AVG_VALID = 1'b1;
         AVG_DATA  = 12'd4095;
         @(negedge ADC_CLK);
         AVG_VALID = 1'b0;
         check_eq("glitch_busy", BUSY, 1);
         check_eq("glitch_no_req", AVG_START, 0);
      end
      wait_avg_start(ok);
      check_eq("req_p", ok, 1);
      check_eq("dac_p", DAC_CODE_OUT, exp_p);
      AVG_VALID = 1'b1;
      AVG_DATA  = 12'(jp);
      @(negedge ADC_CLK);
      AVG_VALID = 1'b0;
      if (drop) begin
         @(negedge ADC_CLK);
         START = 1'b0;
      end
      wait_avg_start(ok);
      check_eq("req_m", ok, 1);
      if (m_delay > 0) begin
         repeat (m_delay) @(negedge ADC_CLK);
         check_eq("delay_busy", BUSY, 1);
         check_eq("delay_no_done", DONE, 0);
      end
      check_eq("dac_m", DAC_CODE_OUT, exp_m);
      AVG_VALID = 1'b1;
      AVG_DATA  = 12'(jm);
      @(negedge ADC_CLK);
      AVG_VALID = 1'b0;
      if (DONE) begin
         ok = 1'b1;
      end else begin
         wait_done(ok);
      end
      check_eq("done_seen", ok, 1);
      DELTA = 14'(next_delta);
      START = next_start;
      @(negedge ADC_CLK);
      check_eq("done_one_cycle", DONE, 0);
      check_eq("base", BASE_CODE_OUT, exp_base);
      check_eq("dac_after_upd", DAC_CODE_OUT, exp_base);
      check_eq("busy_after_upd", BUSY, next_start);
   endtask

   task automatic check_reset_state();
      check_eq("rst_dac", DAC_CODE_OUT, 8192);
      check_eq("rst_base", BASE_CODE_OUT, 8192);
      check_eq("rst_busy", BUSY, 0);
      check_eq("rst_done", DONE, 0);
      check_eq("rst_req", AVG_START, 0);
   endtask

   initial begin
      int  base;
      int  step;
      int  seen;
      bit  ok;
      RST       = 1'b1;
      START     = 1'b0;
      DELTA     = '0;
      AVG_DATA  = '0;
      AVG_VALID = 1'b0;
      repeat (3) @(negedge ADC_CLK);
      check_reset_state();
      RST = 1'b0;

      // Idle for 100 cycles: no request, not busy
      seen = 0;
      repeat (100) begin
         @(negedge ADC_CLK);
         if (AVG_START || BUSY) seen++;
      end
      check_eq("idle_quiet", seen, 0);
      check_eq("idle_dac", DAC_CODE_OUT, 8192);

`ifdef PERTURB_LFSR_EN
      begin
         // bit0 of LFSR states ACE1, 5670, AB38, 559C, 2ACE, 1567, 8AB3, 4559
         logic [7:0] sgn;
         sgn   = 8'b1110_0001;
         DELTA = 14'd100;
         START = 1'b1;
         for (int k = 0; k < 8; k++) begin
            do_iter(1000, 1000, 0, 100, (k < 7), sgn[k] ? 8292 : 8092, sgn[k] ? 8092 : 8292,
                    8192, 0, 0);
         end
      end
`else
      // AVG_VALID in IDLE is ignored
      AVG_VALID = 1'b1;
      AVG_DATA  = 12'd3000;
      @(negedge ADC_CLK);
      AVG_VALID = 1'b0;
      @(negedge ADC_CLK);
      check_eq("idle_valid_busy", BUSY, 0);
      check_eq("idle_valid_base", BASE_CODE_OUT, 8192);

      // Basic iteration: +100/-100 around 8192, dJ=1000 -> +62
      DELTA = 14'd100;
      START = 1'b1;
      do_iter(2000, 1000, 0, 100, 1, 8292, 8092, 8254, 0, 0);
      // Equal metrics with a spurious strobe in SETTLE_P: base unchanged
      do_iter(1000, 1000, 0, 0, 1, 8354, 8154, 8254, 1, 0);
      // Averager answers 500 cycles late in MEAS_M: dJ=1600 -> +100
      do_iter(1600, 0, 500, 0, 1, 8254, 8254, 8354, 0, 0);

      // Walk base up to 16300 with DELTA=0
      base = 8354;
      while (base < 16300) begin
         step = (16300 - base > 255) ? 255 : (16300 - base);
         do_iter(step * 16, 0, 0, (base + step == 16300) ? 200 : 0, 1, base, base, base + step,
                 0, 0);
         base = base + step;
      end
      // High clamp on P phase; J_M exceeds J_P by 4000 -> -250
      do_iter(0, 4000, 0, 0, 1, 16383, 16100, 16050, 0, 0);

      // Walk base down to 50
      base = 16050;
      while (base > 50) begin
         step = (base - 50 > 255) ? 255 : (base - 50);
         do_iter(0, step * 16, 0, (base - step == 50) ? 200 : 0, 1, base, base, base - step,
                 0, 0);
         base = base - step;
      end
      // Low clamp on M phase
      do_iter(500, 500, 0, 100, 1, 250, 0, 50, 0, 0);

      // START released in SETTLE_M: iteration completes, one DONE, then idle
      do_iter(800, 0, 0, 100, 0, 150, 0, 100, 0, 1);
      seen = 0;
      repeat (50) begin
         @(negedge ADC_CLK);
         if (DONE || AVG_START || BUSY) seen++;
      end
      check_eq("drop_idle_quiet", seen, 0);
      check_eq("drop_idle_dac", DAC_CODE_OUT, 100);
      check_eq("drop_idle_base", BASE_CODE_OUT, 100);

      // Reset during MEAS_P
      START = 1'b1;
      wait_avg_start(ok);
      check_eq("req_before_rst", ok, 1);
      RST   = 1'b1;
      START = 1'b0;
      @(negedge ADC_CLK);
      check_reset_state();
      RST = 1'b0;
      AVG_VALID = 1'b1;
      AVG_DATA  = 12'd4000;
      @(negedge ADC_CLK);
      AVG_VALID = 1'b0;
      repeat (3) @(negedge ADC_CLK);
      check_eq("post_rst_busy", BUSY, 0);
      check_eq("post_rst_base", BASE_CODE_OUT, 8192);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
